// File: rtl/sum_dec_pkg.sv
// sum_dec_pkg: shared types and constants for the sum_decrypt block.
//   state_t    : control FSM states {IDLE, SUB, DONE}
//   DEF_WIDTH  : default operand width
//   DEF_STEP   : default bits subtracted per cycle
//   clog2()    : width helper for the bit-position counter
package sum_dec_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SUB  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int DEF_WIDTH = 8;
   localparam int DEF_STEP  = 1;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int v = value - 1; v > 0; v = v >> 1) begin
         r++;
      end
      return r;
   endfunction

endpackage

// File: rtl/dec_sub_slice.sv
// dec_sub_slice: combinational STEP-bit borrow-ripple subtract slice.
//   Computes d = s - b - br_in over STEP bits, LSB first.
// Ports:
//   s      in  STEP  minuend bits
//   b      in  STEP  subtrahend bits
//   br_in  in  1     incoming borrow
//   d      out STEP  difference bits
//   br_out out 1     borrow out of the MSB of the slice
module dec_sub_slice #(
   parameter int STEP = 1
) (
   input  logic [STEP-1:0] s,
   input  logic [STEP-1:0] b,
   input  logic            br_in,
   output logic [STEP-1:0] d,
   output logic            br_out
);

   logic br_v;

   always_comb begin
      br_v = br_in;
      d    = '0;
      for (int j = 0; j < STEP; j++) begin
         d[j] = s[j] ^ b[j] ^ br_v;
         // borrow if s<b at this bit, or equal bits pass the borrow through
         br_v = (~s[j] & b[j]) | (~(s[j] ^ b[j]) & br_v);
      end
      br_out = br_v;
   end

endmodule

// File: rtl/sum_decrypt.sv
// sum_decrypt: recovers plaintext a = ((s - b - c) mod 2^WIDTH) ^ k from the
// output of an XOR-oracle + ripple-carry adder, subtracting STEP bits per
// cycle with a rippled borrow.
// Optional feature macro: DEC_CHECK_EN
//   defined   : err flags a sum inconsistent with any b + c + x, x < 2^WIDTH
//   undefined : err tied low, s[WIDTH] unused
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   input handshake (ready only in IDLE)
//   s [WIDTH:0]         adder sum including carry-out
//   b [WIDTH-1:0]       adder addend
//   c                   adder carry-in
//   k [WIDTH-1:0]       XOR key
//   out_valid/out_ready output handshake (valid only in DONE)
//   a_out [WIDTH-1:0]   recovered plaintext
//   err                 inconsistent-sum flag
module sum_decrypt
   import sum_dec_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int STEP  = DEF_STEP
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH:0]   s,
   input  logic [WIDTH-1:0] b,
   input  logic             c,
   input  logic [WIDTH-1:0] k,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] a_out,
   output logic             err
);

   localparam int            IW       = (clog2(WIDTH) < 1) ? 1 : clog2(WIDTH);
   localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - STEP);

   state_t           state, state_next;
   logic [WIDTH-1:0] s_q, b_q, k_q, d_q;
   logic             br_q;
   logic [IW-1:0]    idx_q;
   logic [STEP-1:0]  slice_d;
   logic             slice_br;
   logic [WIDTH-1:0] d_full;
   logic             final_err;
   logic             last_step;

`ifdef DEC_CHECK_EN
   logic msb_q;
   // a consistent sum carries out exactly when the low-bit subtraction borrows
   assign final_err = (msb_q != slice_br);
`else
   logic unused_msb;
   assign unused_msb = s[WIDTH];
   assign final_err  = 1'b0;
`endif

   assign last_step = (idx_q == LAST_IDX);

   dec_sub_slice #(.STEP(STEP)) u_slice (
      .s      (s_q[idx_q +: STEP]),
      .b      (b_q[idx_q +: STEP]),
      .br_in  (br_q),
      .d      (slice_d),
      .br_out (slice_br)
   );

   // difference word including the slice being computed this cycle, so the
   // final edge can latch a_out without an extra cycle
   always_comb begin
      d_full                 = d_q;
      d_full[idx_q +: STEP]  = slice_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               state_next = SUB;
            end
         end
         SUB: begin
            if (last_step) begin
               state_next = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s_q   <= '0;
         b_q   <= '0;
         k_q   <= '0;
         d_q   <= '0;
         br_q  <= 1'b0;
         idx_q <= '0;
         a_out <= '0;
         err   <= 1'b0;
`ifdef DEC_CHECK_EN
         msb_q <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  s_q   <= s[WIDTH-1:0];
                  b_q   <= b;
                  k_q   <= k;
                  d_q   <= '0;
                  br_q  <= c;
                  idx_q <= '0;
`ifdef DEC_CHECK_EN
                  msb_q <= s[WIDTH];
`endif
               end
            end
            SUB: begin
               d_q   <= d_full;
               br_q  <= slice_br;
               idx_q <= idx_q + IW'(STEP);
               if (last_step) begin
                  a_out <= d_full ^ k_q;
                  err   <= final_err;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_sum_decrypt.sv
// tb_sum_decrypt: directed-vector bench for sum_decrypt (WIDTH=8) with one
// STEP=1 instance and one STEP=4 instance sharing clock and reset.
module tb_sum_decrypt;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

`ifdef DEC_CHECK_EN
   localparam logic EXP_ERR3 = 1'b1;
`else
   localparam logic EXP_ERR3 = 1'b0;
`endif

   // STEP=1 instance
   logic       in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0, c = 1'b0, err;
   logic [8:0] s = '0;
   logic [7:0] b = '0, k = '0, a_out;

   // STEP=4 instance
   logic       in4_valid = 1'b0, in4_ready, out4_valid, out4_ready = 1'b0, err4;
   logic [7:0] a4_out;

   int n_tests = 0;
   int n_fail  = 0;

   sum_decrypt #(.WIDTH(8), .STEP(1)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .s(s), .b(b), .c(c), .k(k),
      .out_valid(out_valid), .out_ready(out_ready), .a_out(a_out), .err(err)
   );

   sum_decrypt #(.WIDTH(8), .STEP(4)) u_dut4 (
      .clk(clk), .rst(rst), .in_valid(in4_valid), .in_ready(in4_ready),
      .s(9'd151), .b(8'd147), .c(1'b0), .k(8'hAA),
      .out_valid(out4_valid), .out_ready(out4_ready), .a_out(a4_out), .err(err4)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // one full transfer on the STEP=1 instance with latency and handshake checks
   task automatic xfer(input string tag, input logic [8:0] sv, input logic [7:0] bv,
                       input logic cv, input logic [7:0] kv,
                       input logic [7:0] exp_a, input logic exp_e);
      int cnt;
      cnt = 0;
      while (!in_ready && cnt < 20) begin
         tick();
         cnt++;
      end
      check({tag, "_in_ready"}, in_ready, 1);
      s = sv; b = bv; c = cv; k = kv;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      cnt = 0;
      while (!out_valid && cnt < 40) begin
         tick();
         cnt++;
      end
      check({tag, "_latency"}, cnt, 8);
      check({tag, "_a_out"}, a_out, exp_a);
      check({tag, "_err"}, err, exp_e);
      check({tag, "_busy"}, in_ready, 0);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check({tag, "_valid_drop"}, out_valid, 0);
      check({tag, "_ready_back"}, in_ready, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int cnt;
      logic seen_valid;
      int rdy_cyc[$];

      // reset state
      tick();
      tick();
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_a_out", a_out, 0);
      check("rst_err", err, 0);
      rst = 1'b0;
      tick();

      // 1: 151-147-0 = 4, ^AA = AE
      xfer("case1", 9'd151, 8'd147, 1'b0, 8'hAA, 8'hAE, 1'b0);
      // 2: full borrow chain, 255-255-1 = FF with carry-out consistent
      xfer("case2", 9'd511, 8'd255, 1'b1, 8'h00, 8'hFF, 1'b0);
      // 3: 5-10 wraps to FB, no carry-out in s -> inconsistent
      xfer("case3", 9'd5, 8'd10, 1'b0, 8'h00, 8'hFB, EXP_ERR3);

      // 4: DONE hold with out_ready low; 200-55-1 = 90, ^0F = 9F
      s = 9'd200; b = 8'd55; c = 1'b1; k = 8'h0F;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      repeat (8) tick();
      check("hold_enter_valid", out_valid, 1);
      check("hold_enter_a", a_out, 8'h9F);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("hold_valid", out_valid, 1);
         check("hold_a", a_out, 8'h9F);
         check("hold_in_ready", in_ready, 0);
      end
      // in_valid together with out_ready in DONE must not be accepted
      s = 9'd151; b = 8'd147; c = 1'b0; k = 8'hAA;
      in_valid = 1'b1;
      out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      out_ready = 1'b0;
      check("hs_valid_drop", out_valid, 0);
      check("hs_in_ready", in_ready, 1);
      tick();
      check("hs_no_accept", in_ready, 1);

      // 5: reset during the 4th SUB cycle
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      repeat (3) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("abort_in_ready", in_ready, 1);
      check("abort_out_valid", out_valid, 0);
      check("abort_a_out", a_out, 0);
      seen_valid = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (out_valid) seen_valid = 1'b1;
      end
      check("abort_no_output", seen_valid, 0);
      xfer("after_abort", 9'd151, 8'd147, 1'b0, 8'hAA, 8'hAE, 1'b0);

      // 6: STEP=4 instance, latency 2 then back-to-back acceptance every 4 cycles
      check("s4_idle_ready", in4_ready, 1);
      in4_valid = 1'b1;
      tick();
      cnt = 0;
      while (!out4_valid && cnt < 20) begin
         tick();
         cnt++;
      end
      check("s4_latency", cnt, 2);
      check("s4_a_out", a4_out, 8'hAE);
      check("s4_err", err4, 0);
      out4_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         tick();
         if (in4_ready) rdy_cyc.push_back(i);
         if (out4_valid) check("s4_stream_a", a4_out, 8'hAE);
      end
      check("s4_accepts", (rdy_cyc.size() >= 4) ? 1 : 0, 1);
      for (int i = 1; i < rdy_cyc.size(); i++) begin
         check("s4_spacing", rdy_cyc[i] - rdy_cyc[i-1], 4);
      end
      in4_valid = 1'b0;
      out4_ready = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
